// File: rtl/biriscv_dmem_bridge.sv
// ---------------------------------------------------------------------------
// biriscv_dmem_bridge
//
// Bridges the biriscv core data port (accept/ack/tag handshake with 4-bit
// byte-strobe writes) onto a word-wide data-memory port that uses separate
// read/write strobes closed by a single-cycle response pulse.
//
// The memory side has no byte enables. A partial write therefore runs as a
// read-modify-write: read the word, merge the strobed bytes, write it back.
// Only one request is in flight at a time. A cycle counter bounds every wait
// on the memory and reports an error when it expires.
//
// Handshake: the core may present a request in any cycle; it is taken on a
// clock edge where mem_d_accept_o is high (bridge idle). Exactly one
// mem_d_ack_o pulse is returned per accepted request, carrying the request's
// tag, an error flag and (for reads) the data. Memory strobes stay high from
// the first cycle of a memory state until the cycle after mem_response_i is
// sampled high; a response seen while no strobe is high has no effect.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   mem_d_addr_i          core byte address
//   mem_d_data_wr_i       core write data
//   mem_d_rd_i            read request
//   mem_d_wr_i            byte write strobes
//   mem_d_flush_i,
//   mem_d_invalidate_i,
//   mem_d_writeback_i     cache-maintenance requests (completed immediately)
//   mem_d_req_tag_i       request tag
//   mem_d_accept_o        request taken this cycle (bridge idle)
//   mem_d_ack_o           one-cycle completion pulse
//   mem_d_error_o         error flag, valid with ack
//   mem_d_data_rd_o       read data, valid with ack
//   mem_d_resp_tag_o      tag of the completed request, valid with ack
//   mem_read_o            memory read strobe
//   mem_write_o           memory write strobe
//   mem_address_o         word-aligned memory address
//   mem_write_data_o      memory write data
//   mem_read_data_i       memory read data, valid with response
//   mem_response_i        memory completion pulse
// ---------------------------------------------------------------------------
module biriscv_dmem_bridge #(
    parameter int TAG_W   = 11,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset_n,

    input  logic [31:0]      mem_d_addr_i,
    input  logic [31:0]      mem_d_data_wr_i,
    input  logic             mem_d_rd_i,
    input  logic [3:0]       mem_d_wr_i,
    input  logic             mem_d_flush_i,
    input  logic             mem_d_invalidate_i,
    input  logic             mem_d_writeback_i,
    input  logic [TAG_W-1:0] mem_d_req_tag_i,
    output logic             mem_d_accept_o,
    output logic             mem_d_ack_o,
    output logic             mem_d_error_o,
    output logic [31:0]      mem_d_data_rd_o,
    output logic [TAG_W-1:0] mem_d_resp_tag_o,

    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic [31:0]      mem_address_o,
    output logic [31:0]      mem_write_data_o,
    input  logic [31:0]      mem_read_data_i,
    input  logic             mem_response_i
);

    // The counter only needs to reach TIMEOUT-1: the expiry is detected in
    // the last waiting cycle so the strobe is high for exactly TIMEOUT cycles.
    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_RMW_RD,
        S_RMW_WR,
        S_WRITE,
        S_RESP
    } state_t;

    state_t           state_q, state_d;

    // Captured request
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       strb_q, strb_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    // Timeout counter
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next values for registered outputs
    logic             read_d, write_d;
    logic [31:0]      addr_d, mwdata_d;
    logic             ack_d, err_d;
    logic [31:0]      rdata_d;
    logic [TAG_W-1:0] rtag_d;

    logic             is_req;
    logic             resp_hit;
    logic             timeout_hit;
    logic [31:0]      merged;

    // Byte offset is irrelevant on a word-wide memory bus.
    logic             unused_addr_bits;
    assign unused_addr_bits = ^mem_d_addr_i[1:0];

    assign mem_d_accept_o = (state_q == S_IDLE);

    assign is_req = mem_d_rd_i | (|mem_d_wr_i) | mem_d_flush_i |
                    mem_d_invalidate_i | mem_d_writeback_i;

    // Only a response that closes an active strobe counts.
    assign resp_hit    = mem_response_i & (mem_read_o | mem_write_o);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    // Read-modify-write merge: strobed bytes come from the core, the rest
    // from the word just read.
    always_comb begin
        merged = '0;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = strb_q[i] ? wdata_q[8*i +: 8] : mem_read_data_i[8*i +: 8];
        end
    end

    always_comb begin
        state_d  = state_q;
        wdata_d  = wdata_q;
        strb_d   = strb_q;
        tag_d    = tag_q;
        cnt_d    = cnt_q;
        read_d   = mem_read_o;
        write_d  = mem_write_o;
        addr_d   = mem_address_o;
        mwdata_d = mem_write_data_o;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        rdata_d  = '0;
        rtag_d   = '0;

        case (state_q)
            S_IDLE: begin
                if (is_req) begin
                    wdata_d = mem_d_data_wr_i;
                    strb_d  = mem_d_wr_i;
                    tag_d   = mem_d_req_tag_i;
                    addr_d  = {mem_d_addr_i[31:2], 2'b00};
                    cnt_d   = '0;
                    if (mem_d_rd_i && (|mem_d_wr_i)) begin
                        // Read and write together is malformed: reject it
                        // without touching memory.
                        state_d = S_RESP;
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                        rtag_d  = mem_d_req_tag_i;
                    end else if (mem_d_rd_i) begin
                        state_d = S_READ;
                        read_d  = 1'b1;
                    end else if (mem_d_wr_i == 4'hF) begin
                        state_d  = S_WRITE;
                        write_d  = 1'b1;
                        mwdata_d = mem_d_data_wr_i;
                    end else if (|mem_d_wr_i) begin
                        state_d = S_RMW_RD;
                        read_d  = 1'b1;
                    end else begin
                        // Cache maintenance: nothing to do on an uncached bus.
                        state_d = S_RESP;
                        ack_d   = 1'b1;
                        rtag_d  = mem_d_req_tag_i;
                    end
                end
            end

            S_READ, S_RMW_RD, S_RMW_WR, S_WRITE: begin
                if (resp_hit) begin
                    if (state_q == S_RMW_RD) begin
                        state_d  = S_RMW_WR;
                        read_d   = 1'b0;
                        write_d  = 1'b1;
                        mwdata_d = merged;
                        cnt_d    = '0;
                    end else begin
                        state_d = S_RESP;
                        read_d  = 1'b0;
                        write_d = 1'b0;
                        ack_d   = 1'b1;
                        rtag_d  = tag_q;
                        if (state_q == S_READ) begin
                            rdata_d = mem_read_data_i;
                        end
                    end
                end else if (timeout_hit) begin
                    state_d = S_RESP;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    rtag_d  = tag_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            wdata_q          <= '0;
            strb_q           <= '0;
            tag_q            <= '0;
            cnt_q            <= '0;
            mem_read_o       <= 1'b0;
            mem_write_o      <= 1'b0;
            mem_address_o    <= '0;
            mem_write_data_o <= '0;
            mem_d_ack_o      <= 1'b0;
            mem_d_error_o    <= 1'b0;
            mem_d_data_rd_o  <= '0;
            mem_d_resp_tag_o <= '0;
        end else begin
            state_q          <= state_d;
            wdata_q          <= wdata_d;
            strb_q           <= strb_d;
            tag_q            <= tag_d;
            cnt_q            <= cnt_d;
            mem_read_o       <= read_d;
            mem_write_o      <= write_d;
            mem_address_o    <= addr_d;
            mem_write_data_o <= mwdata_d;
            mem_d_ack_o      <= ack_d;
            mem_d_error_o    <= err_d;
            mem_d_data_rd_o  <= rdata_d;
            mem_d_resp_tag_o <= rtag_d;
        end
    end

endmodule

// File: tb/tb_biriscv_dmem_bridge.sv
// ---------------------------------------------------------------------------
// tb_biriscv_dmem_bridge
//
// Bench for biriscv_dmem_bridge (TIMEOUT = 8). A table of directed requests
// with hand-computed results, randomized requests whose results come from a
// byte-mask reference model, and hand-written sequences for a late memory
// response and a reset in the middle of a read-modify-write.
// ---------------------------------------------------------------------------
module tb_biriscv_dmem_bridge;

    localparam int TAG_W   = 11;
    localparam int TIMEOUT = 8;
    localparam int BUDGET  = 60;

    // ---------------- clock / reset ----------------
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [31:0]      mem_d_addr_i;
    logic [31:0]      mem_d_data_wr_i;
    logic             mem_d_rd_i;
    logic [3:0]       mem_d_wr_i;
    logic             mem_d_flush_i;
    logic             mem_d_invalidate_i;
    logic             mem_d_writeback_i;
    logic [TAG_W-1:0] mem_d_req_tag_i;
    logic             mem_d_accept_o;
    logic             mem_d_ack_o;
    logic             mem_d_error_o;
    logic [31:0]      mem_d_data_rd_o;
    logic [TAG_W-1:0] mem_d_resp_tag_o;
    logic             mem_read_o;
    logic             mem_write_o;
    logic [31:0]      mem_address_o;
    logic [31:0]      mem_write_data_o;
    logic [31:0]      mem_read_data_i;
    logic             mem_response_i;

    biriscv_dmem_bridge #(
        .TAG_W   (TAG_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .mem_d_addr_i       (mem_d_addr_i),
        .mem_d_data_wr_i    (mem_d_data_wr_i),
        .mem_d_rd_i         (mem_d_rd_i),
        .mem_d_wr_i         (mem_d_wr_i),
        .mem_d_flush_i      (mem_d_flush_i),
        .mem_d_invalidate_i (mem_d_invalidate_i),
        .mem_d_writeback_i  (mem_d_writeback_i),
        .mem_d_req_tag_i    (mem_d_req_tag_i),
        .mem_d_accept_o     (mem_d_accept_o),
        .mem_d_ack_o        (mem_d_ack_o),
        .mem_d_error_o      (mem_d_error_o),
        .mem_d_data_rd_o    (mem_d_data_rd_o),
        .mem_d_resp_tag_o   (mem_d_resp_tag_o),
        .mem_read_o         (mem_read_o),
        .mem_write_o        (mem_write_o),
        .mem_address_o      (mem_address_o),
        .mem_write_data_o   (mem_write_data_o),
        .mem_read_data_i    (mem_read_data_i),
        .mem_response_i     (mem_response_i)
    );

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    // resp_mode: 0 = never respond, 1 = respond to reads and writes,
    //            2 = respond to reads only.
    logic [31:0] mem [0:63];
    int          resp_mode   = 1;
    int          resp_delay  = 0;
    logic        manual_resp = 1'b0;

    initial begin
        int wait_cnt;
        wait_cnt        = 0;
        mem_response_i  = 1'b0;
        mem_read_data_i = '0;
        forever begin
            @(negedge clk);
            mem_response_i  = manual_resp;
            mem_read_data_i = $urandom;
            if (!(mem_read_o || mem_write_o)) begin
                wait_cnt = 0;
            end else if (resp_mode == 1 || (resp_mode == 2 && mem_read_o)) begin
                if (wait_cnt == resp_delay) begin
                    mem_response_i = 1'b1;
                    if (mem_read_o) mem_read_data_i = mem[mem_address_o[7:2]];
                    else            mem[mem_address_o[7:2]] = mem_write_data_o;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // ---------------- vector record ----------------
    typedef struct {
        string            name;
        logic             rd;
        logic [3:0]       wr;
        logic             flush;
        logic             inv;
        logic             wb;
        logic [31:0]      addr;
        logic [31:0]      wdata;
        logic [TAG_W-1:0] tag;
        logic [31:0]      init_word;
        int               delay;
        int               mode;
        logic             exp_err;
        logic [31:0]      exp_data;
        int               exp_lat;
        int               exp_rd;
        int               exp_wr;
        logic [31:0]      exp_word;
    } vec_t;

    function automatic vec_t mk(input string name, input logic rd, input logic [3:0] wr,
                                input logic flush, input logic inv, input logic wb,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [TAG_W-1:0] tag, input logic [31:0] init_word,
                                input int delay, input int mode, input logic exp_err,
                                input logic [31:0] exp_data, input int exp_lat,
                                input int exp_rd, input int exp_wr, input logic [31:0] exp_word);
        vec_t v;
        v.name = name; v.rd = rd; v.wr = wr; v.flush = flush; v.inv = inv; v.wb = wb;
        v.addr = addr; v.wdata = wdata; v.tag = tag; v.init_word = init_word;
        v.delay = delay; v.mode = mode; v.exp_err = exp_err; v.exp_data = exp_data;
        v.exp_lat = exp_lat; v.exp_rd = exp_rd; v.exp_wr = exp_wr; v.exp_word = exp_word;
        return v;
    endfunction

    // Reference model: results derived from the request class, the response
    // delay and a byte mask built from the strobes.
    function automatic vec_t gen_random();
        vec_t        v;
        int          kind;
        logic [31:0] mask;
        logic [2:0]  ops;
        v = mk("rand", 0, 4'h0, 0, 0, 0, $urandom, $urandom, TAG_W'($urandom),
               $urandom, $urandom_range(0, 5), 1, 0, 0, 0, 0, 0, 0);
        kind = $urandom_range(0, 4);
        case (kind)
            0:       v.rd = 1'b1;
            1:       v.wr = 4'hF;
            2:       v.wr = 4'($urandom_range(1, 14));
            3:       begin v.rd = 1'b1; v.wr = 4'($urandom_range(1, 15)); end
            default: begin
                ops = 3'($urandom_range(1, 7));
                {v.flush, v.inv, v.wb} = ops;
            end
        endcase
        if (kind < 4 && $urandom_range(0, 3) == 0) v.flush = 1'b1;

        mask = 0;
        for (int i = 0; i < 4; i++) if (v.wr[i]) mask = mask | (32'hFF << (8 * i));

        v.exp_word = v.init_word;
        if (v.rd && v.wr != 0) begin
            v.exp_err = 1; v.exp_lat = 1;
        end else if (v.rd) begin
            v.exp_data = v.init_word;
            v.exp_lat  = 2 + v.delay;
            v.exp_rd   = v.delay + 1;
        end else if (v.wr == 4'hF) begin
            v.exp_word = v.wdata;
            v.exp_lat  = 2 + v.delay;
            v.exp_wr   = v.delay + 1;
        end else if (v.wr != 0) begin
            v.exp_word = (v.init_word & ~mask) | (v.wdata & mask);
            v.exp_lat  = 3 + 2 * v.delay;
            v.exp_rd   = v.delay + 1;
            v.exp_wr   = v.delay + 1;
        end else begin
            v.exp_lat = 1;
        end
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        mem_d_addr_i       = $urandom;
        mem_d_data_wr_i    = $urandom;
        mem_d_rd_i         = 1'b0;
        mem_d_wr_i         = 4'h0;
        mem_d_flush_i      = 1'b0;
        mem_d_invalidate_i = 1'b0;
        mem_d_writeback_i  = 1'b0;
        mem_d_req_tag_i    = TAG_W'($urandom);
    endtask

    task automatic drive_req(input vec_t v);
        mem_d_addr_i       = v.addr;
        mem_d_data_wr_i    = v.wdata;
        mem_d_rd_i         = v.rd;
        mem_d_wr_i         = v.wr;
        mem_d_flush_i      = v.flush;
        mem_d_invalidate_i = v.inv;
        mem_d_writeback_i  = v.wb;
        mem_d_req_tag_i    = v.tag;
    endtask

    // Issue one request and compare everything observable against the record.
    task automatic run_vec(input vec_t v);
        int               lat, rdc, wrc;
        logic             got_ack, addr_ok, acc_in_ack;
        logic             a_err;
        logic [31:0]      a_data;
        logic [TAG_W-1:0] a_tag;
        logic [31:0]      exp_addr;
        mem[v.addr[7:2]] = v.init_word;
        resp_delay = v.delay;
        resp_mode  = v.mode;
        exp_addr   = {v.addr[31:2], 2'b00};
        lat = 0; rdc = 0; wrc = 0;
        got_ack = 0; addr_ok = 1; acc_in_ack = 0;
        a_err = 0; a_data = 0; a_tag = 0;

        @(negedge clk);
        chk({v.name, ".accept_before"}, 32'(mem_d_accept_o), 32'd1);
        drive_req(v);
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        for (int c = 1; c <= BUDGET && !got_ack; c++) begin
            if (c > 1) @(negedge clk);
            if (mem_read_o)  rdc++;
            if (mem_write_o) wrc++;
            if ((mem_read_o || mem_write_o) && mem_address_o !== exp_addr) addr_ok = 0;
            if (mem_d_ack_o) begin
                got_ack    = 1;
                lat        = c;
                a_err      = mem_d_error_o;
                a_data     = mem_d_data_rd_o;
                a_tag      = mem_d_resp_tag_o;
                acc_in_ack = mem_d_accept_o;
            end
        end
        chk({v.name, ".ack_seen"}, 32'(got_ack), 32'd1);
        if (got_ack) begin
            chk({v.name, ".latency"}, 32'(lat), 32'(v.exp_lat));
            chk({v.name, ".err"}, 32'(a_err), 32'(v.exp_err));
            chk({v.name, ".data"}, a_data, v.exp_data);
            chk({v.name, ".tag"}, 32'(a_tag), 32'(v.tag));
            chk({v.name, ".rd_cycles"}, 32'(rdc), 32'(v.exp_rd));
            chk({v.name, ".wr_cycles"}, 32'(wrc), 32'(v.exp_wr));
            chk({v.name, ".mem_addr"}, 32'(addr_ok), 32'd1);
            chk({v.name, ".accept_in_ack"}, 32'(acc_in_ack), 32'd0);
            @(negedge clk);
            chk({v.name, ".word"}, mem[v.addr[7:2]], v.exp_word);
            chk({v.name, ".ack_single"}, 32'(mem_d_ack_o), 32'd0);
            chk({v.name, ".accept_after"}, 32'(mem_d_accept_o), 32'd1);
        end
        resp_mode = 1;
    endtask

    // ---------------- test ----------------
    vec_t tbl[$];

    initial begin
        int acks, strobes, waited;
        logic seen_wr;

        tbl.push_back(mk("rd_basic",  1, 4'h0, 0, 0, 0, 32'h8000_0010, 32'h0,         5,     32'hDEAD_BEEF, 3, 1, 0, 32'hDEAD_BEEF, 5, 4, 0, 32'hDEAD_BEEF));
        tbl.push_back(mk("wr_full",   0, 4'hF, 0, 0, 0, 32'h8000_0020, 32'h1234_5678, 6,     32'h0,         1, 1, 0, 32'h0,         3, 0, 2, 32'h1234_5678));
        tbl.push_back(mk("rmw_b1",    0, 4'h2, 0, 0, 0, 32'h8000_0030, 32'h0000_1100, 7,     32'hAABB_CCDD, 2, 1, 0, 32'h0,         7, 3, 3, 32'hAABB_11DD));
        tbl.push_back(mk("rd_wr_err", 1, 4'h3, 0, 0, 0, 32'h8000_0040, 32'hFFFF_FFFF, 8,     32'h1111_1111, 0, 1, 1, 32'h0,         1, 0, 0, 32'h1111_1111));
        tbl.push_back(mk("flush",     0, 4'h0, 1, 0, 0, 32'h8000_0044, 32'h0,         9,     32'h2222_2222, 0, 1, 0, 32'h0,         1, 0, 0, 32'h2222_2222));
        tbl.push_back(mk("inval",     0, 4'h0, 0, 1, 0, 32'h8000_0048, 32'h0,         10,    32'h3333_3333, 0, 1, 0, 32'h0,         1, 0, 0, 32'h3333_3333));
        tbl.push_back(mk("wback",     0, 4'h0, 0, 0, 1, 32'h8000_004C, 32'h0,         11,    32'h4444_4444, 0, 1, 0, 32'h0,         1, 0, 0, 32'h4444_4444));
        tbl.push_back(mk("rd_fast",   1, 4'h0, 0, 0, 0, 32'h8000_0053, 32'h0,         11'h7FF, 32'hCAFE_F00D, 0, 1, 0, 32'hCAFE_F00D, 2, 1, 0, 32'hCAFE_F00D));
        tbl.push_back(mk("rmw_b9",    0, 4'h9, 0, 0, 0, 32'h8000_0060, 32'hA1B2_C3D4, 3,     32'h0102_0304, 0, 1, 0, 32'h0,         3, 1, 1, 32'hA102_03D4));
        tbl.push_back(mk("to_read",   1, 4'h0, 0, 0, 0, 32'h8000_0070, 32'h0,         12,    32'h5555_5555, 0, 0, 1, 32'h0,         9, 8, 0, 32'h5555_5555));
        tbl.push_back(mk("to_rmw_rd", 0, 4'h1, 0, 0, 0, 32'h8000_0074, 32'h0000_00FF, 13,    32'h6666_6666, 0, 0, 1, 32'h0,         9, 8, 0, 32'h6666_6666));
        tbl.push_back(mk("to_rmw_wr", 0, 4'h4, 0, 0, 0, 32'h8000_0078, 32'h00AB_0000, 14,    32'h7777_7777, 1, 2, 1, 32'h0,         11, 2, 8, 32'h7777_7777));
        tbl.push_back(mk("to_write",  0, 4'hF, 0, 0, 0, 32'h8000_007C, 32'h9999_9999, 15,    32'h8888_8888, 0, 0, 1, 32'h0,         9, 0, 8, 32'h8888_8888));

        idle_inputs();
        for (int i = 0; i < 64; i++) mem[i] = $urandom;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst.read",   32'(mem_read_o), 32'd0);
        chk("rst.write",  32'(mem_write_o), 32'd0);
        chk("rst.addr",   mem_address_o, 32'd0);
        chk("rst.wdata",  mem_write_data_o, 32'd0);
        chk("rst.ack",    32'(mem_d_ack_o), 32'd0);
        chk("rst.err",    32'(mem_d_error_o), 32'd0);
        chk("rst.data",   mem_d_data_rd_o, 32'd0);
        chk("rst.tag",    32'(mem_d_resp_tag_o), 32'd0);
        chk("rst.accept", 32'(mem_d_accept_o), 32'd1);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed table
        foreach (tbl[i]) run_vec(tbl[i]);

        // Late response after the timeout above, and a stray response while idle
        acks = 0; strobes = 0;
        manual_resp = 1'b1;
        @(negedge clk);
        @(negedge clk);
        manual_resp = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (mem_d_ack_o) acks++;
            if (mem_read_o || mem_write_o) strobes++;
        end
        chk("late_resp.acks", 32'(acks), 32'd0);
        chk("late_resp.strobes", 32'(strobes), 32'd0);
        chk("late_resp.accept", 32'(mem_d_accept_o), 32'd1);

        // Reset while the write leg of a read-modify-write is pending
        mem[36] = 32'h1357_9BDF;
        resp_delay = 3;
        resp_mode  = 1;
        @(negedge clk);
        drive_req(mk("rst_rmw", 0, 4'h1, 0, 0, 0, 32'h8000_0090, 32'h0000_00EE, 21,
                     0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        seen_wr = 0; waited = 0;
        while (!seen_wr && waited < BUDGET) begin
            @(negedge clk);
            waited++;
            if (mem_write_o) seen_wr = 1;
        end
        chk("rst_rmw.reached_write", 32'(seen_wr), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_rmw.read",  32'(mem_read_o), 32'd0);
        chk("rst_rmw.write", 32'(mem_write_o), 32'd0);
        chk("rst_rmw.addr",  mem_address_o, 32'd0);
        chk("rst_rmw.wdata", mem_write_data_o, 32'd0);
        chk("rst_rmw.ack",   32'(mem_d_ack_o), 32'd0);
        chk("rst_rmw.data",  mem_d_data_rd_o, 32'd0);
        chk("rst_rmw.tag",   32'(mem_d_resp_tag_o), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        acks = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (mem_d_ack_o) acks++;
        end
        chk("rst_rmw.no_ack", 32'(acks), 32'd0);
        chk("rst_rmw.word_kept", mem[36], 32'h1357_9BDF);
        run_vec(mk("rd_after_rst", 1, 4'h0, 0, 0, 0, 32'h8000_0094, 32'h0, 22,
                   32'h2468_ACE0, 2, 1, 0, 32'h2468_ACE0, 4, 3, 0, 32'h2468_ACE0));

        // Randomized requests against the reference model
        for (int n = 0; n < 200; n++) run_vec(gen_random());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global bound on simulated time
    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: got=expired expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
